// File: rtl/cevero_dvfs_actuator.sv
// Applies DVFS operating-point requests to the regulator and clock generator, stepping voltage
// one code per settle interval and gating the core clock while the PLL relocks.
module cevero_dvfs_actuator #(
    parameter int unsigned V_SETTLE    = 4,
    parameter int unsigned LOCK_CYCLES = 8,
    parameter int unsigned V_MIN       = 1,
    parameter int unsigned DEF_VOLTAGE = 5,
    parameter int unsigned DEF_FREQ    = 150
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [2:0]  req_voltage_i,
    input  logic [31:0] req_freq_i,
    output logic [2:0]  vdd_code_o,
    output logic [31:0] freq_o,
    output logic        clk_gate_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned CntMax = (V_SETTLE > LOCK_CYCLES) ? V_SETTLE : LOCK_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [2:0]      VMin       = 3'(V_MIN);
    localparam logic [2:0]      VDef       = 3'(DEF_VOLTAGE);
    localparam logic [31:0]     FDef       = 32'(DEF_FREQ);
    localparam logic [CntW-1:0] SettleLoad = CntW'(V_SETTLE - 1);
    localparam logic [CntW-1:0] LockLoad   = CntW'(LOCK_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StVup,
        StFreq,
        StLock,
        StVdown,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  vdd_q, vdd_d;
    logic [31:0] freq_q, freq_d;
    logic        gate_q, gate_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]  tgt_v_q, tgt_v_d;
    logic [31:0] tgt_f_q, tgt_f_d;

    logic [2:0]  tv;
    logic [31:0] tf;

    // A zero frequency request means "keep the current frequency".
    assign tv = (req_voltage_i < VMin) ? VMin : req_voltage_i;
    assign tf = (req_freq_i == '0) ? freq_q : req_freq_i;

    always_comb begin
        state_d = state_q;
        vdd_d   = vdd_q;
        freq_d  = freq_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        tgt_v_d = tgt_v_q;
        tgt_f_d = tgt_f_q;

        unique case (state_q)
            StIdle: begin
                if ((tv != vdd_q) || (tf != freq_q)) begin
                    tgt_v_d = tv;
                    tgt_f_d = tf;
                    cnt_d   = '0;
                    if (tv > vdd_q) begin
                        state_d = StVup;
                    end else if (tf != freq_q) begin
                        state_d = StFreq;
                    end else begin
                        state_d = StVdown;
                    end
                end
            end

            // cnt_q==0 marks a step edge; the exit is taken on the last settle edge so the
            // next action lands exactly V_SETTLE cycles after the final step.
            StVup: begin
                if (cnt_q == '0) begin
                    if (vdd_q == tgt_v_q) begin
                        state_d = (tgt_f_q != freq_q) ? StFreq : StDone;
                    end else begin
                        vdd_d = vdd_q + 3'd1;
                        cnt_d = SettleLoad;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                    if ((cnt_q == CntOne) && (vdd_q == tgt_v_q)) begin
                        state_d = (tgt_f_q != freq_q) ? StFreq : StDone;
                    end
                end
            end

            StFreq: begin
                freq_d  = tgt_f_q;
                gate_d  = 1'b0;
                cnt_d   = LockLoad;
                state_d = StLock;
            end

            StLock: begin
                if (cnt_q == '0) begin
                    gate_d  = 1'b1;
                    state_d = (tgt_v_q < vdd_q) ? StVdown : StDone;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end

            StVdown: begin
                if (cnt_q == '0) begin
                    if (vdd_q == tgt_v_q) begin
                        state_d = StDone;
                    end else begin
                        vdd_d = vdd_q - 3'd1;
                        cnt_d = SettleLoad;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                    if ((cnt_q == CntOne) && (vdd_q == tgt_v_q)) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            vdd_q   <= VDef;
            freq_q  <= FDef;
            gate_q  <= 1'b1;
            cnt_q   <= '0;
            tgt_v_q <= VDef;
            tgt_f_q <= FDef;
        end else begin
            state_q <= state_d;
            vdd_q   <= vdd_d;
            freq_q  <= freq_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            tgt_v_q <= tgt_v_d;
            tgt_f_q <= tgt_f_d;
        end
    end

    assign vdd_code_o = vdd_q;
    assign freq_o     = freq_q;
    assign clk_gate_o = gate_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);

endmodule

// File: doc/cevero_dvfs_actuator.md
Name: cevero_dvfs_actuator

Overview:
Consumer side of the DVFS controller's operating-point outputs. It accepts the requested voltage code and frequency and drives the regulator code and clock-generator frequency word. Changes are sequenced safely: voltage rises before frequency rises, and frequency falls before voltage falls. Voltage moves one code per settle interval, and the core clock is gated while the clock generator relocks. It sits between cevero_dvfs and the regulator/PLL interface.

Parameters:
V_SETTLE, 4, cycles held after each single-code voltage step (>=1)
LOCK_CYCLES, 8, cycles clk_gate_o stays low after a frequency change (>=1)
V_MIN, 1, lowest legal voltage code; requests below are clamped up to it
DEF_VOLTAGE, 5, reset value of vdd_code_o
DEF_FREQ, 150, reset value of freq_o

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
req_voltage_i  input  3  requested voltage code (from set_voltage_o)
req_freq_i  input  32  requested frequency word (from set_freq_o)
vdd_code_o  output  3  applied regulator code
freq_o  output  32  applied clock-generator frequency word
clk_gate_o  output  1  core clock enable; 0 while PLL relocks
busy_o  output  1  transition in progress
done_o  output  1  one-cycle pulse when a transition completes

Behaviour:
- One clock domain, clk_i. rst_ni is asynchronous and active-low.
- Reset values: vdd_code_o=DEF_VOLTAGE, freq_o=DEF_FREQ, clk_gate_o=1, busy_o=0, done_o=0, state=IDLE, counter=0.
- Effective target voltage tv = max(req_voltage_i, V_MIN).
- Effective target frequency tf = req_freq_i. If req_freq_i==0, tf = current freq_o, so a zero request never changes the frequency.
- States: IDLE, VUP, FREQ, LOCK, VDOWN, DONE.
- IDLE:
  - Compares tv and tf against the applied values each cycle.
  - On a mismatch at edge N, latches tv/tf into target registers. busy_o=1 from edge N+1.
  - If tv>vdd: go to VUP. Otherwise, if tf!=freq: go to FREQ. Otherwise (only tv<vdd): go to VDOWN.
- VUP:
  - On each step's first edge, vdd_code_o += 1, then hold V_SETTLE cycles.
  - When vdd==target, go to FREQ if the frequency differs, else go to DONE.
- FREQ: for one cycle, freq_o<=target_f and clk_gate_o<=0 at the same edge, then go to LOCK.
- LOCK:
  - Counts LOCK_CYCLES cycles in total, counting from the edge where clk_gate_o fell.
  - Then clk_gate_o<=1. Go to VDOWN if target_v<vdd, else go to DONE.
- VDOWN: mirrors VUP with vdd_code_o -= 1 per step, then go to DONE.
- DONE: one cycle, done_o=1, busy_o=1. Then go to IDLE, where busy_o=0.
- Only one code step at a time. vdd_code_o never skips codes and never goes below V_MIN or above 7.
- Requests that change while busy_o=1 are ignored. The latched target completes first, and IDLE re-samples on the cycle after DONE. Back-to-back requests therefore always incur a DONE cycle.
- A mid-operation reset immediately restores all reset values, including clk_gate_o=1. No partial step is retained.
- Frequency direction alone never changes order. Voltage-up paths always apply frequency after the voltage; voltage-down paths always apply it before.
- The settle counter is wide enough for max(V_SETTLE, LOCK_CYCLES). It reloads on every step and never wraps mid-step.

Test Plan:
- Reset mid-LOCK (rst_ni low for 1 cycle) -> vdd_code_o=5, freq_o=150, clk_gate_o=1, busy_o=0 immediately (asynchronous).
- Raise: req 7/200 from 5/150 -> vdd 6, then 7 four cycles later; four cycles after that freq_o=200 and clk_gate_o low for 8 cycles; then done_o pulse. busy_o=1 throughout; latency 1+8+8+1=18 cycles.
- Lower: req 3/100 from 7/200 -> freq_o=100 first, gate low 8 cycles, then vdd 6,5,4,3 at 4-cycle spacing; then done_o; no voltage change before clk_gate_o returns high.
- Frequency only: req 3/120 -> vdd_code_o unchanged, freq_o=120, gate low 8 cycles, done_o pulse; total 10 cycles busy.
- Boundaries:
  - req_voltage_i=0 -> clamped to V_MIN=1.
  - req_freq_i=0 with same voltage -> no transition, busy_o stays 0.
- Request change while busy: switch req to 7/150 during a lower-direction VDOWN -> current ramp finishes to 3, done_o pulses, then a new VUP starts on the next cycle.
